// File: rtl/prog_table_fsm_pkg.sv
// Shared definitions for the programmable table-driven Moore FSM:
// table select encodings, default parameter values and a table-depth helper.
package prog_table_fsm_pkg;

    // cfg_sel encodings
    localparam logic CFG_SEL_NS  = 1'b0;
    localparam logic CFG_SEL_OUT = 1'b1;

    // Default parameter values
    localparam int DEF_IN_W        = 2;
    localparam int DEF_ST_W        = 3;
    localparam int DEF_OUT_W       = 3;
    localparam int DEF_RESET_STATE = 0;
    localparam int DEF_CNT_W       = 8;

    // Number of entries addressed by an addr_w-bit index:
    // ST_W+IN_W for the next-state table, ST_W for the output table.
    function automatic int table_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// Register-file table: async active-low clear to RESET_VAL, one synchronous
// write port and one combinational read port. Reads return the pre-edge
// contents, so a same-edge write is only seen from the following cycle.
module prog_fsm_table
    import prog_table_fsm_pkg::*;
#(
    parameter int             AW        = 3,
    parameter int             DEPTH     = table_depth(AW),
    parameter int             W         = 3,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]     mem_reg [DEPTH];
    logic [DEPTH-1:0] wsel;

    // One-hot write select per entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wsel[gi] = we && (waddr == AW'(gi));
        end
    endgenerate

    // Table storage: cleared asynchronously, written only at the selected entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    // Combinational read
    always_comb begin
        rdata = mem_reg[raddr];
    end

endmodule

// File: rtl/prog_table_fsm.sv
// Run-time programmable Moore FSM. Next-state and output functions are held
// in two register-file tables loaded through the cfg_* port; the state
// register and a saturating step counter advance on en, restart wins over en.
module prog_table_fsm
    import prog_table_fsm_pkg::*;
#(
    parameter int IN_W        = DEF_IN_W,
    parameter int ST_W        = DEF_ST_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int RESET_STATE = DEF_RESET_STATE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 restart,
    input  logic [IN_W-1:0]      sym_in,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [ST_W+IN_W-1:0] cfg_addr,
    input  logic [ST_W-1:0]      cfg_ns,
    input  logic [OUT_W-1:0]     cfg_out,
    output logic [ST_W-1:0]      state,
    output logic [OUT_W-1:0]     out,
    output logic                 self_loop,
    output logic [CNT_W-1:0]     step_cnt
);

    localparam logic [ST_W-1:0]  RST_ST  = ST_W'(RESET_STATE);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ST_W-1:0]  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ST_W-1:0]  ns_rd;
    logic [OUT_W-1:0] out_rd;
    logic             ns_we, out_we;

    assign ns_we  = cfg_we && (cfg_sel == CFG_SEL_NS);
    assign out_we = cfg_we && (cfg_sel == CFG_SEL_OUT);

    // Next-state table indexed by {state, symbol}; unprogrammed entries lead home
    prog_fsm_table #(
        .AW        (ST_W + IN_W),
        .DEPTH     (table_depth(ST_W + IN_W)),
        .W         (ST_W),
        .RESET_VAL (RST_ST)
    ) u_ns_tab (
        .clk   (clk),
        .reset (reset),
        .we    (ns_we),
        .waddr (cfg_addr),
        .wdata (cfg_ns),
        .raddr ({state_reg, sym_in}),
        .rdata (ns_rd)
    );

    // Output table indexed by state; upper cfg_addr bits are ignored
    prog_fsm_table #(
        .AW        (ST_W),
        .DEPTH     (table_depth(ST_W)),
        .W         (OUT_W),
        .RESET_VAL ('0)
    ) u_out_tab (
        .clk   (clk),
        .reset (reset),
        .we    (out_we),
        .waddr (cfg_addr[ST_W-1:0]),
        .wdata (cfg_out),
        .raddr (state_reg),
        .rdata (out_rd)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RST_ST;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state / counter logic: restart beats en, counter saturates
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (restart) begin
            state_next = RST_ST;
            cnt_next   = '0;
        end else if (en) begin
            state_next = ns_rd;
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    assign state     = state_reg;
    assign out       = out_rd;
    assign self_loop = (ns_rd == state_reg);
    assign step_cnt  = cnt_reg;

endmodule

// File: tb/tb_prog_table_fsm.sv
// Directed self-checking bench for prog_table_fsm (CNT_W=4 so saturation is
// reachable in a few cycles). Inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that updated them.
module tb_prog_table_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] sym_in = '0;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [4:0] cfg_addr = '0;
    logic [2:0] cfg_ns = '0;
    logic [2:0] cfg_out = '0;
    logic [2:0] state;
    logic [2:0] out;
    logic       self_loop;
    logic [3:0] step_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    prog_table_fsm #(
        .IN_W        (2),
        .ST_W        (3),
        .OUT_W       (3),
        .RESET_STATE (0),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .restart   (restart),
        .sym_in    (sym_in),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_ns    (cfg_ns),
        .cfg_out   (cfg_out),
        .state     (state),
        .out       (out),
        .self_loop (self_loop),
        .step_cnt  (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        check_cnt++;
        if (obs == exp) begin
            pass_cnt++;
            $display("check %-14s obs=%0d exp=%0d ok", tag, obs, exp);
        end else begin
            $display("FAIL %-14s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_ns(input int st, input int sym, input int ns);
        cfg_we   = 1'b1;
        cfg_sel  = 1'b0;
        cfg_addr = 5'((st << 2) | sym);
        cfg_ns   = 3'(ns);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic wr_out(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_sel  = 1'b1;
        cfg_addr = 5'(addr);
        cfg_out  = 3'(val);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic step(input int sym, input int n);
        en     = 1'b1;
        sym_in = 2'(sym);
        for (int i = 0; i < n; i++) tick();
        en     = 1'b0;
    endtask

    initial begin
        // ---- Reset check with non-default tables loaded ----
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_ns(0, 3, 5);
        wr_out(0, 2);
        wr_out(5, 7);
        step(3, 1);
        check("pre_rst_state", state, 5);
        check("pre_rst_out", out, 7);
        #2 reset = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_out", out, 0);
        check("rst_cnt", step_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b1;
        sym_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_run_state", state, 0);
        end
        check("rst_self_loop", self_loop, 1);
        check("rst_run_cnt", step_cnt, 4);
        en = 1'b0;

        // ---- Counter FSM: 0->1->...->7->0 on symbol 0, OUT[k]=k ----
        for (int k = 0; k < 8; k++) begin
            wr_ns(k, 0, (k + 1) % 8);
            wr_out(k, k);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("cntr_restart", step_cnt, 0);
        en = 1'b1;
        sym_in = 2'd0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("cntr_out", out, (i + 1) % 8);
        end
        en = 1'b0;
        check("cntr_cnt", step_cnt, 9);

        // ---- Symbol branching from state 2 on symbol 2 ----
        wr_ns(2, 2, 5);
        step(0, 1);
        check("br_pre_state", state, 2);
        step(2, 1);
        check("br_state", state, 5);
        check("br_out", out, 5);
        check("br_cnt", step_cnt, 11);
        check("br_self_loop", self_loop, 0);
        for (int i = 0; i < 3; i++) tick();
        check("hold_state", state, 5);
        check("hold_out", out, 5);
        check("hold_cnt", step_cnt, 11);

        // ---- Collision: NS write and transition on the same edge ----
        restart = 1'b1;
        tick();
        restart = 1'b0;
        step(0, 3);
        check("col_pre_state", state, 3);
        en       = 1'b1;
        sym_in   = 2'd0;
        cfg_we   = 1'b1;
        cfg_sel  = 1'b0;
        cfg_addr = 5'b011_00;
        cfg_ns   = 3'd6;
        tick();
        cfg_we   = 1'b0;
        en       = 1'b0;
        check("col_old_entry", state, 4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        step(0, 4);
        check("col_new_entry", state, 6);
        check("col_out", out, 6);
        // OUT write to current state with junk upper address bits
        wr_out(5'b111_10, 1);
        check("outwr_cur", out, 1);
        check("outwr_state", state, 6);

        // ---- Restart priority over en, then counter saturation ----
        check("rs_pre_cnt", step_cnt, 4);
        en = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_state", state, 0);
        check("rs_cnt", step_cnt, 0);
        // cycle is now 0,1,2,3,6,7 (period 6): 20 steps lands on 2
        for (int i = 0; i < 20; i++) tick();
        en = 1'b0;
        check("sat_cnt", step_cnt, 15);
        check("sat_state", state, 2);
        check("sat_out", out, 2);

        // ---- Async reset mid-run clears state, counter and tables ----
        en = 1'b1;
        sym_in = 2'd0;
        #2 reset = 1'b0;
        #1;
        check("ar_state", state, 0);
        check("ar_out", out, 0);
        check("ar_cnt", step_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("ar_run_state", state, 0);
        end
        en = 1'b0;
        check("ar_run_out", out, 0);
        check("ar_self_loop", self_loop, 1);
        check("ar_run_cnt", step_cnt, 9);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
